// File: rtl/word_entry_buffer_pkg.sv
// rtl/word_entry_buffer_pkg.sv - shared key codes, blank code and FSM encoding
// No ports: constants and types imported by word_entry_buffer and its classifier.
package word_entry_buffer_pkg;

    localparam logic [7:0] KEY_BS       = 8'h08;
    localparam logic [7:0] KEY_ENTER    = 8'h0D;
    localparam logic [7:0] ASCII_A      = 8'h41;
    localparam logic [7:0] ASCII_Z      = 8'h5A;
    localparam logic [7:0] LOWER_OFFSET = 8'h20;
    localparam logic [7:0] BLANK_CODE   = 8'h20;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLR  = 2'd1,
        S_DRAW = 2'd2
    } state_t;

endpackage

// File: rtl/word_entry_buffer_key_classify.sv
// rtl/word_entry_buffer_key_classify.sv - combinational decode of a key code
// Ports: key_code (in, 8) ASCII code; is_letter/is_bs/is_enter (out) class flags;
//        folded_code (out, 8) key code with lowercase folded to uppercase.
module word_entry_buffer_key_classify
    import word_entry_buffer_pkg::*;
(
    input  logic [7:0] key_code,
    output logic       is_letter,
    output logic       is_bs,
    output logic       is_enter,
    output logic [7:0] folded_code
);

    localparam logic [7:0] LOWER_A = ASCII_A + LOWER_OFFSET;
    localparam logic [7:0] LOWER_Z = ASCII_Z + LOWER_OFFSET;

    logic is_upper;
    logic is_lower;

    assign is_upper    = (key_code >= ASCII_A) && (key_code <= ASCII_Z);
    assign is_lower    = (key_code >= LOWER_A) && (key_code <= LOWER_Z);
    assign is_letter   = is_upper || is_lower;
    assign is_bs       = (key_code == KEY_BS);
    assign is_enter    = (key_code == KEY_ENTER);
    assign folded_code = is_lower ? (key_code - LOWER_OFFSET) : key_code;

endmodule

// File: rtl/word_entry_buffer.sv
// rtl/word_entry_buffer.sv - key-driven letter buffer that sequences one redraw per edit
// Ports: clock, reset_n (async active-low); key_valid/key_code/key_ready key handshake;
//        clear request; letters/letter_num buffer state; draw_clear_n/draw_enable/draw_done
//        drawer control; word_valid Enter pulse; overflow dropped-letter pulse.
module word_entry_buffer
    import word_entry_buffer_pkg::*;
#(
    parameter int         MAX_LETTERS = 10,
    parameter int         NUM_W       = 4,
    parameter logic [7:0] BLANK_CODE  = word_entry_buffer_pkg::BLANK_CODE
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     key_valid,
    input  logic [7:0]               key_code,
    output logic                     key_ready,
    input  logic                     clear,
    output logic [8*MAX_LETTERS-1:0] letters,
    output logic [NUM_W-1:0]         letter_num,
    output logic                     draw_clear_n,
    output logic                     draw_enable,
    input  logic                     draw_done,
    output logic                     word_valid,
    output logic                     overflow
);

    localparam logic [NUM_W-1:0] MAX_NUM = NUM_W'(MAX_LETTERS);

    state_t     state;
    logic       pending_key_valid;
    logic [7:0] pending_key;
    logic       pending_clear;
    logic       dirty;

    logic       is_letter;
    logic       is_bs;
    logic       is_enter;
    logic [7:0] folded_code;
    logic       accept_key;

    // A key arriving together with clear is consumed by the handshake but thrown away.
    assign key_ready  = !pending_key_valid;
    assign accept_key = key_valid && key_ready && !clear;

    word_entry_buffer_key_classify key_classify (
        .key_code    (pending_key),
        .is_letter   (is_letter),
        .is_bs       (is_bs),
        .is_enter    (is_enter),
        .folded_code (folded_code)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state             <= S_IDLE;
            pending_key_valid <= 1'b0;
            pending_key       <= 8'h00;
            pending_clear     <= 1'b0;
            dirty             <= 1'b1;
            letters           <= {MAX_LETTERS{BLANK_CODE}};
            letter_num        <= '0;
            draw_clear_n      <= 1'b1;
            draw_enable       <= 1'b0;
            word_valid        <= 1'b0;
            overflow          <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            overflow   <= 1'b0;
            if (clear) begin
                pending_clear <= 1'b1;
            end
            if (accept_key) begin
                pending_key_valid <= 1'b1;
                pending_key       <= key_code;
            end

            case (state)
                S_IDLE: begin
                    if (pending_clear) begin
                        // A clear arriving this same cycle stays queued for another pass.
                        pending_clear     <= clear;
                        pending_key_valid <= accept_key;
                        letters           <= {MAX_LETTERS{BLANK_CODE}};
                        letter_num        <= '0;
                        draw_clear_n      <= 1'b0;
                        state             <= S_CLR;
                    end else if (dirty) begin
                        draw_clear_n <= 1'b0;
                        state        <= S_CLR;
                    end else if (pending_key_valid) begin
                        pending_key_valid <= 1'b0;
                        if (is_letter) begin
                            if (letter_num < MAX_NUM) begin
                                for (int i = 0; i < MAX_LETTERS; i++) begin
                                    if (NUM_W'(i) == letter_num) begin
                                        letters[8*i +: 8] <= folded_code;
                                    end
                                end
                                letter_num   <= letter_num + 1'b1;
                                draw_clear_n <= 1'b0;
                                state        <= S_CLR;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end else if (is_bs) begin
                            if (letter_num != '0) begin
                                for (int i = 0; i < MAX_LETTERS; i++) begin
                                    if (NUM_W'(i) == letter_num - 1'b1) begin
                                        letters[8*i +: 8] <= BLANK_CODE;
                                    end
                                end
                                letter_num   <= letter_num - 1'b1;
                                draw_clear_n <= 1'b0;
                                state        <= S_CLR;
                            end
                        end else if (is_enter) begin
                            word_valid <= 1'b1;
                        end
                    end
                end
                S_CLR: begin
                    draw_clear_n <= 1'b1;
                    draw_enable  <= 1'b1;
                    dirty        <= 1'b0;
                    state        <= S_DRAW;
                end
                S_DRAW: begin
                    if (draw_done) begin
                        draw_enable <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_word_entry_buffer.sv
// tb/tb_word_entry_buffer.sv - directed self-checking bench for word_entry_buffer
module tb_word_entry_buffer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [7:0]  key_code = 8'h00;
    logic        key_ready;
    logic        clear = 1'b0;
    logic [79:0] letters;
    logic [3:0]  letter_num;
    logic        draw_clear_n;
    logic        draw_enable;
    logic        draw_done;
    logic        word_valid;
    logic        overflow;

    int pass_cnt = 0;
    int total_cnt = 0;

    int clr_cnt = 0;
    int en_cycles = 0;
    int wv_cnt = 0;
    int ovf_cnt = 0;
    logic [2:0] dcnt = 3'd0;

    always #5 clock = ~clock;

    word_entry_buffer dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_ready    (key_ready),
        .clear        (clear),
        .letters      (letters),
        .letter_num   (letter_num),
        .draw_clear_n (draw_clear_n),
        .draw_enable  (draw_enable),
        .draw_done    (draw_done),
        .word_valid   (word_valid),
        .overflow     (overflow)
    );

    // Drawer model: counter cleared by draw_clear_n, counts while enabled, done at 4.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) dcnt <= 3'd0;
        else if (!draw_clear_n) dcnt <= 3'd0;
        else if (draw_enable && dcnt < 3'd4) dcnt <= dcnt + 3'd1;
    end
    assign draw_done = (dcnt == 3'd4);

    always @(negedge clock) begin
        if (reset_n) begin
            if (!draw_clear_n) clr_cnt <= clr_cnt + 1;
            if (draw_enable) en_cycles <= en_cycles + 1;
            if (word_valid) wv_cnt <= wv_cnt + 1;
            if (overflow) ovf_cnt <= ovf_cnt + 1;
        end
    end

    typedef struct {
        logic [7:0] code;
        logic [3:0] num;
        int         slot;
        logic [7:0] slot_val;
        int         redraws;
        int         wvs;
    } vec_t;

    vec_t vecs[7];
    localparam logic [79:0] ALL_BLANK = {10{8'h20}};
    localparam logic [79:0] ALL_A     = {10{8'h41}};

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Offer a key and hold it until the handshake takes it (bounded).
    task automatic offer_key(input logic [7:0] code);
        bit ok;
        ok = 1'b0;
        @(negedge clock);
        key_valid = 1'b1;
        key_code  = code;
        for (int i = 0; i < 60; i++) begin
            if (key_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check("key_accept_timeout", 80'(ok), 80'd1);
        @(posedge clock);
        @(negedge clock);
        key_valid = 1'b0;
    endtask

    task automatic wait_enable(input logic level, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (draw_enable == level) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 80'(ok), 80'd1);
    endtask

    function automatic logic [7:0] slot_of(input logic [79:0] l, input int s);
        return l[8*s +: 8];
    endfunction

    initial begin
        int c0, w0, o0;

        vecs[0] = '{8'h63, 4'd1, 0, 8'h43, 1, 0};
        vecs[1] = '{8'h41, 4'd2, 1, 8'h41, 1, 0};
        vecs[2] = '{8'h74, 4'd3, 2, 8'h54, 1, 0};
        vecs[3] = '{8'h08, 4'd2, 2, 8'h20, 1, 0};
        vecs[4] = '{8'h0D, 4'd2, 1, 8'h41, 0, 1};
        vecs[5] = '{8'h31, 4'd2, 0, 8'h43, 0, 0};
        vecs[6] = '{8'h7A, 4'd3, 2, 8'h5A, 1, 0};

        // Reset state
        #12;
        check("rst_letters", letters, ALL_BLANK);
        check("rst_num", 80'(letter_num), 80'd0);
        check("rst_ready", 80'(key_ready), 80'd1);
        check("rst_clear_n", 80'(draw_clear_n), 80'd1);
        check("rst_enable", 80'(draw_enable), 80'd0);
        check("rst_wv_ovf", 80'({word_valid, overflow}), 80'd0);

        // Release: one redraw, enable high for 5 cycles
        @(negedge clock);
        reset_n = 1'b1;
        cycles(20);
        check("boot_redraws", 80'(clr_cnt), 80'd1);
        check("boot_enable_cycles", 80'(en_cycles), 80'd5);
        check("boot_letters", letters, ALL_BLANK);

        // Table-driven key edits
        for (int v = 0; v < 7; v++) begin
            c0 = clr_cnt;
            w0 = wv_cnt;
            offer_key(vecs[v].code);
            cycles(12);
            check($sformatf("vec%0d_num", v), 80'(letter_num), 80'(vecs[v].num));
            check($sformatf("vec%0d_slot", v), 80'(slot_of(letters, vecs[v].slot)), 80'(vecs[v].slot_val));
            check($sformatf("vec%0d_redraws", v), 80'(clr_cnt - c0), 80'(vecs[v].redraws));
            check($sformatf("vec%0d_wv", v), 80'(wv_cnt - w0), 80'(vecs[v].wvs));
        end

        // clear and 'X' in the same cycle: key discarded
        c0 = clr_cnt;
        @(negedge clock);
        clear = 1'b1;
        key_valid = 1'b1;
        key_code = 8'h58;
        @(negedge clock);
        clear = 1'b0;
        key_valid = 1'b0;
        check("clrx_ready", 80'(key_ready), 80'd1);
        cycles(12);
        check("clrx_letters", letters, ALL_BLANK);
        check("clrx_num", 80'(letter_num), 80'd0);
        check("clrx_redraws", 80'(clr_cnt - c0), 80'd1);

        // Backspace at 0 is a no-op
        c0 = clr_cnt;
        offer_key(8'h08);
        cycles(12);
        check("bs0_num", 80'(letter_num), 80'd0);
        check("bs0_redraws", 80'(clr_cnt - c0), 80'd0);

        // Ten 'A' then 'B': overflow once, no eleventh redraw
        c0 = clr_cnt;
        o0 = ovf_cnt;
        for (int i = 0; i < 10; i++) begin
            offer_key(8'h41);
            cycles(12);
        end
        offer_key(8'h42);
        cycles(12);
        check("full_num", 80'(letter_num), 80'd10);
        check("full_letters", letters, ALL_A);
        check("full_ovf", 80'(ovf_cnt - o0), 80'd1);
        check("full_redraws", 80'(clr_cnt - c0), 80'd10);

        // Empty the buffer, then keys during a redraw
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        cycles(12);
        check("clr2_num", 80'(letter_num), 80'd0);
        offer_key(8'h4D);
        wait_enable(1'b1, "m_enable_timeout");
        key_valid = 1'b1;
        key_code = 8'h51;
        @(negedge clock);
        check("q_taken_ready", 80'(key_ready), 80'd0);
        key_code = 8'h52;
        cycles(2);
        check("q_stall_ready", 80'(key_ready), 80'd0);
        check("q_frozen_num", 80'(letter_num), 80'd1);
        check("q_frozen_slot1", 80'(slot_of(letters, 1)), 80'h20);
        wait_enable(1'b0, "q_done_timeout");
        for (int i = 0; i < 60; i++) begin
            if (key_ready) break;
            @(negedge clock);
        end
        @(posedge clock);
        @(negedge clock);
        key_valid = 1'b0;
        cycles(12);
        check("qr_num", 80'(letter_num), 80'd3);
        check("qr_slot1", 80'(slot_of(letters, 1)), 80'h51);
        check("qr_slot2", 80'(slot_of(letters, 2)), 80'h52);

        // Reset asserted mid-draw, then a fresh redraw after release
        offer_key(8'h4B);
        wait_enable(1'b1, "k_enable_timeout");
        reset_n = 1'b0;
        #1;
        check("midrst_enable", 80'(draw_enable), 80'd0);
        check("midrst_num", 80'(letter_num), 80'd0);
        check("midrst_letters", letters, ALL_BLANK);
        c0 = clr_cnt;
        @(negedge clock);
        reset_n = 1'b1;
        cycles(12);
        check("midrst_redraw", 80'(clr_cnt - c0), 80'd1);
        check("midrst_idle_enable", 80'(draw_enable), 80'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
